act_mem_readout_streamer: RTL and testbench
===========================================

Name: act_mem_readout_streamer

Overview:
- Reader-side counterpart of the external write port into the activation memory.
- On command, it reads a contiguous run of activation-memory rows, each N_DIM_ARRAY bytes wide, and streams them out as 32-bit words on a valid/ready interface.
- It sits between the activation SRAM read port and the host/uDMA readback path.
- It handles the 1-cycle SRAM read latency under backpressure with a 2-entry buffer and credit-based read issue.

Parameters:
- N_DIM_ARRAY, 4, byte lanes per activation row.
- DATA_WIDTH, 8, bits per lane (INPUT_CHANNEL_DATA_WIDTH).
- ROW_ADDR_W, 13, row address width (log2(2^15 / N_DIM_ARRAY)).
- LEN_W, 14, word-count width (max 2^ROW_ADDR_W words).

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe, sampled only in IDLE.
- base_row  in  ROW_ADDR_W  first row to read.
- length  in  LEN_W  number of rows/words to stream.
- busy  out  1  high from accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse when the transfer is complete.
- mem_req  out  1  SRAM read enable.
- mem_addr  out  ROW_ADDR_W  SRAM row address.
- mem_rdata  in  N_DIM_ARRAY*DATA_WIDTH  SRAM data, valid the cycle after mem_req.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer ready.
- out_data  out  N_DIM_ARRAY*DATA_WIDTH  output word; lane i = byte i of the row at bits [DATA_WIDTH*i +: DATA_WIDTH].
- out_last  out  1  marks the final word of the transfer.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: busy=0, done=0, mem_req=0, mem_addr=0, out_valid=0, out_data=0, out_last=0. FIFO is empty, inflight=0, counters=0, FSM=IDLE.
- Reset mid-transfer: the transfer is abandoned and all state is cleared. A read already in flight is discarded; its mem_rdata the next cycle is ignored.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and length!=0: latch base_row into rd_addr; latch length into issue_cnt and pop_cnt; go to RUN; busy=1.
  - start=1 and length=0: go to DONE directly; no mem_req, no output words.
- RUN:
  - mem_req = (issue_cnt!=0) and (fifo_count + inflight - pop < 2), where pop = out_valid & out_ready.
  - mem_addr = rd_addr.
  - On each issue: rd_addr increments modulo 2^ROW_ADDR_W (row 8191 wraps to 0); issue_cnt decrements.
  - When issue_cnt reaches 0, go to DRAIN.
- DRAIN: no mem_req. When pop_cnt reaches 0 (last handshake), go to DONE.
- DONE: done=1 for one cycle; busy stays 1 in this cycle; next state IDLE.
- start while busy is ignored.
- inflight register: set to 1 in the cycle after mem_req, 0 otherwise. Its mem_rdata is pushed into the FIFO at the end of that cycle.
- FIFO: depth 2, registered, fall-through head.
  - out_valid = (fifo_count != 0); out_data = head entry.
  - Push and pop in the same cycle are both honoured and the count is unchanged.
  - Overflow is impossible by the credit rule. The bench checks the invariant fifo_count + inflight <= 2.
- Output handshake:
  - A word transfers when out_valid & out_ready.
  - Once out_valid is asserted, out_data and out_last stay stable until the handshake.
  - Each pop decrements pop_cnt.
  - out_last = out_valid & (pop_cnt==1).
- Latency:
  - start sampled at edge E0; mem_req is high in the cycle after E0 (cycle 1).
  - Data is written to the FIFO at the end of cycle 2; out_valid is first high in cycle 3.
- Throughput: 1 word/cycle sustained when out_ready is held high.
- Backpressure: with out_ready low, at most 2 reads are outstanding or buffered; mem_req stays low until a pop frees a slot.
- Done timing: done is high in the cycle after the last handshake.

Test Plan:
- Reset, then start with base_row=0x010, length=4, out_ready=1, memory row r holding {r+3,r+2,r+1,r} bytes -> mem_addr 0x010..0x013 on consecutive cycles; out_data 0x13121110, 0x14131211, 0x15141312, 0x16151413 on cycles 3-6; out_last on the 4th word; done on cycle 7.
- Same transfer with out_ready toggling 1,0,0,1,... -> no word lost or duplicated; out_data held stable while out_ready=0; mem_req never raises fifo_count+inflight above 2.
- base_row=0x1FFE, length=4 -> mem_addr sequence 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- length=0 -> no mem_req, no out_valid; busy and done are high exactly one cycle after start.
- Assert reset in the cycle after the 2nd handshake of a length=8 transfer -> all outputs 0 the next cycle; a fresh start with length=2 then completes with exactly 2 words.
- Pulse start again during RUN with a different base_row -> ignored; the original transfer completes unchanged.

Source files
------------

// File: rtl/act_mem_readout_streamer_if.sv
// Output word stream of the activation-memory readout path: valid/ready handshake
// carrying one packed activation row per beat, with a last-word marker.
interface act_mem_readout_streamer_if #(
  parameter int DW = 32
) ();
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/act_mem_readout_streamer.sv
// Reads a contiguous run of activation-memory rows and streams them out one row per
// word, absorbing the 1-cycle SRAM latency with a 2-entry buffer and read credits.
module act_mem_readout_streamer #(
  parameter int N_DIM_ARRAY = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ROW_ADDR_W  = 13,
  parameter int LEN_W       = 14
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [ROW_ADDR_W-1:0]             base_row,
  input  logic [LEN_W-1:0]                  length,
  output logic                              busy,
  output logic                              done,
  output logic                              mem_req,
  output logic [ROW_ADDR_W-1:0]             mem_addr,
  input  logic [N_DIM_ARRAY*DATA_WIDTH-1:0] mem_rdata,
  act_mem_readout_streamer_if.master        stream
);

  localparam int WORD_W = N_DIM_ARRAY * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [ROW_ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]      issue_cnt;
  logic [LEN_W-1:0]      pop_cnt;
  logic                  inflight;
  logic [WORD_W-1:0]     fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;
  logic                  pop;
  logic [2:0]            credit_used;

  assign pop         = stream.out_valid & stream.out_ready;
  // A slot is committed from the moment its read is issued, not when data lands.
  assign credit_used = {1'b0, fifo_count} + {2'b00, inflight};

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = (length == '0) ? DONE : RUN;
      end
      RUN: begin
        mem_req = (issue_cnt != '0) && (credit_used < 3'd2 + {2'b00, pop});
        if (mem_req && issue_cnt == LEN_W'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && pop_cnt == LEN_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign mem_addr = rd_addr;

  assign stream.out_valid = (fifo_count != 2'd0);
  assign stream.out_data  = stream.out_valid ? fifo_mem[rd_ptr] : '0;
  assign stream.out_last  = stream.out_valid && (pop_cnt == LEN_W'(1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rd_addr    <= '0;
      issue_cnt  <= '0;
      pop_cnt    <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      state    <= state_nxt;
      inflight <= mem_req;

      if (state == IDLE && start && length != '0) begin
        rd_addr   <= base_row;
        issue_cnt <= length;
        pop_cnt   <= length;
      end

      // Row address wraps naturally at 2^ROW_ADDR_W.
      if (mem_req) begin
        rd_addr   <= rd_addr + ROW_ADDR_W'(1);
        issue_cnt <= issue_cnt - LEN_W'(1);
      end

      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        pop_cnt <= pop_cnt - LEN_W'(1);
      end

      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // NOTE: buffer storage has no reset; out_data is masked while empty, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (inflight) fifo_mem[wr_ptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_act_mem_readout_streamer.sv
// Randomized bench for act_mem_readout_streamer: a transfer-level model (expected row
// sequence, issue/pop counts, done timing) is checked every cycle, plus literal directed cases.
module tb_act_mem_readout_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [12:0] base_row = '0;
  logic [13:0] length = '0;
  logic        busy, done, mem_req;
  logic [12:0] mem_addr;
  logic [31:0] mem_rdata = '0;

  act_mem_readout_streamer_if #(.DW(32)) stream ();

  act_mem_readout_streamer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_row  (base_row),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .stream    (stream)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: lane i of row r holds byte (r+i).
  function automatic logic [31:0] row_word(input int r);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(r + i);
    return w;
  endfunction

  // SRAM model: data valid the cycle after the request, garbage otherwise.
  always @(posedge clk) mem_rdata <= mem_req ? row_word(int'(mem_addr)) : $urandom();

  // Consumer ready pattern
  int ready_mode = 0;
  int ready_idx = 0;
  initial stream.out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    ready_idx++;
    case (ready_mode)
      0:       stream.out_ready = 1'b1;
      1:       stream.out_ready = (ready_idx % 3 == 0);
      default: stream.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Transfer-level model state
  bit          exp_busy = 0, exp_done = 0, after_reset = 0;
  int          m_base = 0, m_len = 0, issued = 0, popped = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data;
  bit          prev_last;
  int          cyc = 0, start_cyc = 0;
  int          log_addr[$];
  logic [31:0] log_data[$];
  bit          log_done_seen = 0;
  int          log_done_rel = -1, first_valid_rel = -1, first_req_rel = -1;

  always @(negedge clk) begin
    bit nxt_busy, nxt_done;
    cyc++;
    if (after_reset) begin
      check("rst_out_valid", 32'(stream.out_valid), 0);
      check("rst_out_data", stream.out_data, 0);
      check("rst_out_last", 32'(stream.out_last), 0);
      check("rst_mem_req", 32'(mem_req), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      after_reset = 0;
    end
    check("busy", 32'(busy), 32'(exp_busy));
    check("done", 32'(done), 32'(exp_done));
    if (done) begin
      log_done_seen = 1;
      log_done_rel  = cyc - start_cyc;
    end
    nxt_busy = exp_busy && !exp_done;
    nxt_done = 0;

    if (mem_req) begin
      check("req_in_xfer", 32'(exp_busy && !exp_done && issued < m_len), 1);
      check("mem_addr", 32'(mem_addr), 32'((m_base + issued) % 8192));
      if (first_req_rel < 0) first_req_rel = cyc - start_cyc;
      log_addr.push_back(int'(mem_addr));
      issued++;
    end

    if (stream.out_valid) begin
      if (first_valid_rel < 0) first_valid_rel = cyc - start_cyc;
      check("valid_in_xfer", 32'(exp_busy && popped < m_len), 1);
      if (popped < m_len) begin
        check("out_data", stream.out_data, row_word(m_base + popped));
        check("out_last", 32'(stream.out_last), 32'(popped == m_len - 1));
      end
      if (prev_stall) begin
        check("data_held", stream.out_data, prev_data);
        check("last_held", 32'(stream.out_last), 32'(prev_last));
      end
      if (stream.out_ready) begin
        log_data.push_back(stream.out_data);
        popped++;
        if (popped == m_len) nxt_done = 1;
      end
    end else if (prev_stall) begin
      check("valid_held", 32'(stream.out_valid), 1);
    end
    prev_stall = stream.out_valid && !stream.out_ready;
    prev_data  = stream.out_data;
    prev_last  = stream.out_last;

    if (exp_busy) check("outstanding_le_2", 32'(issued - popped <= 2), 1);

    if (!exp_busy && start) begin
      nxt_busy = 1;
      nxt_done = (length == 0);
      m_base = int'(base_row);
      m_len  = int'(length);
      issued = 0;
      popped = 0;
      start_cyc = cyc;
      log_addr.delete();
      log_data.delete();
      log_done_seen = 0;
      log_done_rel = -1;
      first_valid_rel = -1;
      first_req_rel = -1;
    end

    if (reset) begin
      nxt_busy = 0;
      nxt_done = 0;
      after_reset = 1;
      prev_stall = 0;
      issued = 0;
      popped = 0;
      m_len = 0;
    end
    exp_busy = nxt_busy;
    exp_done = nxt_done;
  end

  // Called at posedge+1; returns at posedge+1 after done has been observed.
  task automatic do_xfer(input int b, input int l, input int mode, input bit interfere);
    int n;
    ready_mode = mode;
    start = 1'b1;
    base_row = 13'(b);
    length = 14'(l);
    @(posedge clk); #1;
    start = 1'b0;
    if (interfere) begin
      start = 1'b1;
      base_row = 13'(b) ^ 13'h155;
      length = 14'd3;
      @(posedge clk); #1;
      start = 1'b0;
    end
    n = 0;
    while (!log_done_seen && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("xfer_done_seen", 32'(log_done_seen), 1);
    #1;
  endtask

  logic [31:0] t1_words[4];
  int          t3_addrs[4];

  initial begin
    int n;
    t1_words = '{32'h13121110, 32'h14131211, 32'h15141312, 32'h16151413};
    t3_addrs = '{32'h1FFE, 32'h1FFF, 32'h0000, 32'h0001};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Latency / throughput with free-running consumer
    do_xfer(32'h010, 4, 0, 0);
    check("t1_first_req_rel", 32'(first_req_rel), 1);
    check("t1_first_valid_rel", 32'(first_valid_rel), 3);
    check("t1_done_rel", 32'(log_done_rel), 7);
    check("t1_n_words", 32'(log_data.size()), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", 32'(i < log_addr.size() ? log_addr[i] : -1), 32'h10 + 32'(i));
      check("t1_word", i < log_data.size() ? log_data[i] : 32'hDEADBEEF, t1_words[i]);
    end

    // Same transfer under 1,0,0 backpressure
    do_xfer(32'h010, 4, 1, 0);
    check("t2_n_words", 32'(log_data.size()), 4);
    check("t2_n_reqs", 32'(log_addr.size()), 4);
    for (int i = 0; i < 4; i++)
      check("t2_word", i < log_data.size() ? log_data[i] : 32'hDEADBEEF, t1_words[i]);

    // Row address wrap
    do_xfer(32'h1FFE, 4, 0, 0);
    for (int i = 0; i < 4; i++)
      check("t3_addr", 32'(i < log_addr.size() ? log_addr[i] : -1), 32'(t3_addrs[i]));
    check("t3_word2", log_data.size() > 2 ? log_data[2] : 32'hDEADBEEF, 32'h03020100);

    // Zero length
    do_xfer(32'h055, 0, 0, 0);
    check("t4_done_rel", 32'(log_done_rel), 1);
    check("t4_n_reqs", 32'(log_addr.size()), 0);
    check("t4_first_valid", 32'(first_valid_rel), 32'(-1));

    // Reset in the cycle after the 2nd handshake of a length-8 transfer
    ready_mode = 0;
    start = 1'b1;
    base_row = 13'h0A0;
    length = 14'd8;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (log_data.size() < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("t5_two_words_seen", 32'(log_data.size() >= 2), 1);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    do_xfer(32'h0B7, 2, 2, 0);
    check("t5_n_words", 32'(log_data.size()), 2);
    check("t5_word0", log_data.size() > 0 ? log_data[0] : 32'hDEADBEEF, 32'hBAB9B8B7);

    // Start pulse during RUN is ignored
    do_xfer(32'h040, 5, 0, 1);
    check("t6_n_words", 32'(log_data.size()), 5);
    check("t6_last_addr", 32'(log_addr.size() == 5 ? log_addr[4] : -1), 32'h44);
    check("t6_word0", log_data.size() > 0 ? log_data[0] : 32'hDEADBEEF, 32'h43424140);

    // Randomized transfers
    for (int k = 0; k < 30; k++) begin
      int b, l, md;
      bit itf;
      b   = $urandom_range(0, 8191);
      l   = $urandom_range(0, 20);
      md  = $urandom_range(0, 2);
      itf = 1'($urandom_range(0, 1));
      do_xfer(b, l, md, itf);
      check("rand_n_words", 32'(log_data.size()), 32'(l));
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
